// File: rtl/pi_error_seq64_water.sv
// pi_error_seq64_water: computes error = ref - meas (IEEE double) once per
// solver step, publishes it on x with done_read_x, then pulses sta LEAD cycles
// later for the downstream PI limiter stage.
module pi_error_seq64_water #(
  parameter int SUB_LATENCY = 7,
  parameter int LEAD        = 10,
  parameter int NEG_ERR     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rst_user,
  input  logic        start,
  input  logic [63:0] ref_val,
  input  logic [63:0] meas,
  output logic [63:0] x,
  output logic        done_read_x,
  output logic        sta,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_LEAD, S_STA} state_t;

  // a - b in IEEE double, round-to-nearest-even, denormals and specials handled
  function automatic logic [63:0] fp_sub(input logic [63:0] a, input logic [63:0] b_in);
    logic [63:0]  b, big, sml;
    logic         a_nan, b_nan, a_inf, b_inf, sl, ss, found, rnd;
    logic [11:0]  el, es, dd, e_n, lz, sh;
    logic [55:0]  ml, ms, mn;
    logic [111:0] wide;
    logic [56:0]  sum;
    logic [53:0]  mr;
    b     = {~b_in[63], b_in[62:0]};
    a_nan = (&a[62:52]) && (|a[51:0]);
    b_nan = (&b[62:52]) && (|b[51:0]);
    a_inf = (&a[62:52]) && !(|a[51:0]);
    b_inf = (&b[62:52]) && !(|b[51:0]);
    if (a_nan) return a | 64'h0008_0000_0000_0000;
    if (b_nan) return b_in | 64'h0008_0000_0000_0000;
    if (a_inf && b_inf && (a[63] != b[63])) return 64'h7FF8_0000_0000_0000;
    if (a_inf) return a;
    if (b_inf) return b;
    big = (a[62:0] >= b[62:0]) ? a : b;
    sml = (a[62:0] >= b[62:0]) ? b : a;
    sl  = big[63];
    ss  = sml[63];
    el  = (big[62:52] == 11'd0) ? 12'd1 : {1'b0, big[62:52]};
    es  = (sml[62:52] == 11'd0) ? 12'd1 : {1'b0, sml[62:52]};
    ml  = {(big[62:52] != 11'd0), big[51:0], 3'b000};
    ms  = {(sml[62:52] != 11'd0), sml[51:0], 3'b000};
    // align the smaller operand; everything shifted past bit 0 folds into sticky
    dd  = el - es;
    if (dd > 12'd60) dd = 12'd60;
    wide = {ms, 56'd0} >> dd;
    ms   = wide[111:56];
    ms[0] = ms[0] | (|wide[55:0]);
    if (sl == ss) sum = {1'b0, ml} + {1'b0, ms};
    else          sum = {1'b0, ml} - {1'b0, ms};
    if (sum == '0) return {((sl == ss) ? sl : 1'b0), 63'd0};
    if (sum[56]) begin
      mn  = sum[56:1] | {55'd0, sum[0]};
      e_n = el + 12'd1;
    end else begin
      lz    = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 56; i++) begin
        if (!found) begin
          if (sum[55-i]) found = 1'b1;
          else           lz = lz + 12'd1;
        end
      end
      // normalisation stops at exponent 1 so tiny results come out subnormal
      sh  = (lz < el - 12'd1) ? lz : el - 12'd1;
      mn  = sum[55:0] << sh;
      e_n = el - sh;
    end
    rnd = mn[2] & (mn[1] | mn[0] | mn[3]);
    mr  = {1'b0, mn[55:3]} + 54'(rnd);
    if (mr[53]) begin
      mr  = mr >> 1;
      e_n = e_n + 12'd1;
    end
    if (e_n >= 12'd2047) return {sl, 11'h7FF, 52'd0};
    return {sl, (mr[52] ? e_n[10:0] : 11'd0), mr[51:0]};
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [63:0] opa_q, opa_d, opb_q, opb_d;
  logic [63:0] x_q, x_d;
  logic        done_q, done_d, sta_q, sta_d, busy_q, busy_d, ovr_q, ovr_d;
  logic [63:0] diff, sub_res;

  assign diff = fp_sub(opa_q, opb_q);

  if (SUB_LATENCY > 1) begin : g_pipe
    logic [63:0] pipe_q [SUB_LATENCY-1];
    // free-running subtractor pipeline; only its output at the SUB->LEAD step is used
    always_ff @(posedge clk) begin
      pipe_q[0] <= diff;
      for (int unsigned i = 1; i < SUB_LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign sub_res = pipe_q[SUB_LATENCY-2];
  end else begin : g_nopipe
    assign sub_res = diff;
  end

  // sequencer next state: user reset, then start acceptance, then step timing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    x_d     = x_q;
    done_d  = 1'b0;
    sta_d   = 1'b0;
    busy_d  = busy_q;
    ovr_d   = ovr_q;
    if (rst_user) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      x_d     = '0;
      busy_d  = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (start && busy_q) ovr_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            opa_d   = (NEG_ERR != 0) ? meas : ref_val;
            opb_d   = (NEG_ERR != 0) ? ref_val : meas;
            cnt_d   = 16'(SUB_LATENCY - 1);
            state_d = S_SUB;
            busy_d  = 1'b1;
          end
        end
        S_SUB: begin
          if (cnt_q == '0) begin
            x_d     = sub_res;
            done_d  = 1'b1;
            cnt_d   = 16'(LEAD - 1);
            state_d = S_LEAD;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_LEAD: begin
          if (cnt_q == '0) begin
            sta_d   = 1'b1;
            state_d = S_STA;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // sequencer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      done_q  <= 1'b0;
      sta_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      done_q  <= done_d;
      sta_q   <= sta_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  // operand registers need no reset: they are only consumed after a start
  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
  end

  assign x           = x_q;
  assign done_read_x = done_q;
  assign sta         = sta_q;
  assign busy        = busy_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_pi_error_seq64_water.sv
// Bench for pi_error_seq64_water: two instances (default timing with
// NEG_ERR=0, minimum timing with NEG_ERR=1) checked against an event-time
// reference model using native double arithmetic.
module tb_pi_error_seq64_water;

  logic        clk = 1'b0;
  logic        rst, rst_user, start;
  logic [63:0] ref_val, meas;
  logic [63:0] x_o [2];
  logic        dr_o [2], sta_o [2], busy_o [2], ovr_o [2];

  always #5 clk = ~clk;

  pi_error_seq64_water #(.SUB_LATENCY(7), .LEAD(10), .NEG_ERR(0)) dut0 (
    .clk(clk), .rst(rst), .rst_user(rst_user), .start(start),
    .ref_val(ref_val), .meas(meas), .x(x_o[0]), .done_read_x(dr_o[0]),
    .sta(sta_o[0]), .busy(busy_o[0]), .overrun(ovr_o[0]));

  pi_error_seq64_water #(.SUB_LATENCY(1), .LEAD(1), .NEG_ERR(1)) dut1 (
    .clk(clk), .rst(rst), .rst_user(rst_user), .start(start),
    .ref_val(ref_val), .meas(meas), .x(x_o[1]), .done_read_x(dr_o[1]),
    .sta(sta_o[1]), .busy(busy_o[1]), .overrun(ovr_o[1]));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // model state per instance
  int          sl_m [2] = '{7, 1};
  int          ld_m [2] = '{10, 1};
  bit          act  [2];
  int          t0   [2];
  logic [63:0] val  [2];
  logic [63:0] ex   [2];
  bit          ov   [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] canon(input logic [63:0] v);
    if (v[62:52] == 11'h7FF && v[51:0] != 52'd0) return 64'h7FF8_0000_0000_0000;
    return v;
  endfunction

  function automatic logic [63:0] ref_diff(input logic [63:0] a, input logic [63:0] b);
    real r;
    r = $bitstoreal(a) - $bitstoreal(b);
    return $realtobits(r);
  endfunction

  function automatic bit m_busy(input int i, input int k);
    return act[i] && k >= t0[i] + 1 && k <= t0[i] + 1 + sl_m[i] + ld_m[i];
  endfunction

  // one clock cycle: drive inputs, check outputs mid-cycle, advance the model
  task automatic step(input logic s, input logic su, input logic r,
                      input logic [63:0] rv, input logic [63:0] mv);
    int dcyc;
    bit edone, esta;
    start = s; rst_user = su; rst = r; ref_val = rv; meas = mv;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      dcyc  = t0[i] + 1 + sl_m[i];
      edone = act[i] && cyc == dcyc;
      esta  = act[i] && cyc == dcyc + ld_m[i];
      if (edone) ex[i] = val[i];
      chk($sformatf("x%0d", i), canon(x_o[i]), canon(ex[i]));
      chk($sformatf("done%0d", i), 64'(dr_o[i]), 64'(edone));
      chk($sformatf("sta%0d", i), 64'(sta_o[i]), 64'(esta));
      chk($sformatf("busy%0d", i), 64'(busy_o[i]), 64'(m_busy(i, cyc)));
      chk($sformatf("ovr%0d", i), 64'(ovr_o[i]), 64'(ov[i]));
    end
    for (int i = 0; i < 2; i++) begin
      if (r || su) begin
        act[i] = 1'b0; ex[i] = '0; ov[i] = 1'b0;
      end else if (s) begin
        if (m_busy(i, cyc)) ov[i] = 1'b1;
        else begin
          act[i] = 1'b1;
          t0[i]  = cyc;
          val[i] = (i == 1) ? ref_diff(mv, rv) : ref_diff(rv, mv);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] rand_dbl(input logic [63:0] near);
    logic [63:0] v;
    case ($urandom_range(0, 9))
      0: v = 64'h0000_0000_0000_0000;
      1: v = 64'h8000_0000_0000_0000;
      2: v = {$urandom_range(0, 1) == 1, 11'h7FF, 52'd0};
      3: v = {1'b0, 11'h7FF, 20'd1, $urandom};
      4: v = {$urandom_range(0, 1) == 1, 11'd0, 20'($urandom), $urandom};
      5: v = near ^ 64'($urandom_range(0, 255));
      6: v = {near[63:52] + 12'($urandom_range(0, 3)), 20'($urandom), $urandom};
      7: v = {near[63:62], 10'($urandom_range(0, 3)), 20'($urandom), $urandom};
      default: v = rnd64();
    endcase
    return v;
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, rnd64(), rnd64());
  endtask

  localparam logic [63:0] D1P0  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] D0P25 = 64'h3FD0_0000_0000_0000;
  localparam logic [63:0] D2P5  = 64'h4004_0000_0000_0000;

  initial begin
    logic [63:0] a, b;
    bit s, su, r;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; t0[i] = 0; val[i] = '0; ex[i] = '0; ov[i] = 1'b0;
    end
    rst = 1'b1; rst_user = 1'b0; start = 1'b0; ref_val = '0; meas = '0;
    repeat (3) @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b1, '0, '0);
    idle(2);

    // default vector and its sign-swapped counterpart
    step(1'b1, 1'b0, 1'b0, D1P0, D0P25);
    idle(22);
    step(1'b1, 1'b0, 1'b0, D0P25, D1P0);
    idle(22);

    // start while busy at relative cycle 5 sets sticky overrun
    for (int c = 0; c < 24; c++) step(c == 0 || c == 5, 1'b0, 1'b0, D1P0, D0P25);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    idle(2);

    // back-to-back starts at relative cycles 0 and 19
    for (int c = 0; c < 42; c++)
      step(c == 0 || c == 19, 1'b0, 1'b0, (c < 19) ? D1P0 : D2P5, (c < 19) ? D0P25 : D1P0);

    // rst_user during LEAD, restart two cycles later
    for (int c = 0; c < 36; c++) step(c == 0 || c == 14, c == 12, 1'b0, D2P5, D0P25);

    // rst mid-SUB; then rst together with start
    for (int c = 0; c < 22; c++) step(c == 0, 1'b0, c == 3, D1P0, D0P25);
    step(1'b1, 1'b0, 1'b1, D1P0, D0P25);
    idle(22);

    // start together with rst_user is dropped
    step(1'b1, 1'b1, 1'b0, D1P0, D0P25);
    idle(22);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      a  = rand_dbl(rnd64());
      b  = rand_dbl(a);
      s  = ($urandom_range(0, 7) == 0);
      su = ($urandom_range(0, 99) == 0);
      r  = ($urandom_range(0, 199) == 0);
      step(s, su, r, a, b);
    end
    idle(25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
